spi_sram_burst: RTL and testbench

Parametrised SPI-slave front end with embedded SRAM, the successor to the fixed 8-bit shift/count/SRAM datapath. A frame carries a command byte, an address and one or more data words. Reads and writes run as bursts with address auto-increment and wrap. Data width, address width and bit order are parameters. Frame errors are reported.

---
 rtl/spi_sram_burst.sv | 188 ++++++++++++++++++
 tb/tb_spi_sram_burst.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_burst.sv
// SPI-slave front end with embedded SRAM: command, address, then burst data words
// with address auto-increment and wrap. Width and bit order are parameters.
module spi_sram_burst #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic SCK,
    input  logic rst_n,
    input  logic csN,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic wordDone,
    output logic frameErr
);

    localparam int MAX_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int SH_W   = (MAX_AD > 8) ? MAX_AD : 8;
    localparam int IDX_W  = $clog2(SH_W);
    localparam int CNT_W  = (IDX_W + 1 > 5) ? IDX_W + 1 : 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_IGNORE
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [SH_W-1:0]     sh_q;
    logic [DATA_W-1:0]   tx_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                rd_q;
    logic                miso_q;
    logic                word_done_q;
    logic                frame_err_q;

    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic [SH_W-1:0]     asm_d;
    logic [ADDR_W-1:0]   addr_inc;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_word;
    logic                last_cmd;
    logic                last_addr;
    logic                last_word;
    logic                mem_we;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        if (LSB_FIRST != 0) return w[0];
        else                return w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
        if (LSB_FIRST != 0) return {1'b0, w[DATA_W-1:1]};
        else                return {w[DATA_W-2:0], 1'b0};
    endfunction

    // Field assembly including the bit on MOSI this edge; sh_q is cleared at
    // every phase start, so the low bits of asm_d always hold the current field.
    always_comb begin
        asm_d = sh_q;
        if (LSB_FIRST != 0) asm_d[cnt_q[IDX_W-1:0]] = MOSI;
        else                asm_d = {sh_q[SH_W-2:0], MOSI};
    end

    always_comb begin
        last_cmd  = (cnt_q == CNT_W'(7));
        last_addr = (cnt_q == CNT_W'(ADDR_W - 1));
        last_word = (cnt_q == CNT_W'(DATA_W - 1));
        addr_inc  = addr_q + ADDR_W'(1);
        rd_addr   = (state_q == S_ADDR) ? asm_d[ADDR_W-1:0] : addr_inc;
        rd_word   = mem[rd_addr];
        mem_we    = !csN && (state_q == S_DATA) && !rd_q && last_word;
    end

    always_ff @(posedge SCK) begin
        if (mem_we) mem[addr_q] <= asm_d[DATA_W-1:0];
    end

    always_ff @(posedge SCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            miso_q      <= 1'b0;
            word_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            word_done_q <= 1'b0;
            if (csN) begin
                // A deselect is only clean at a word boundary of the data phase.
                if ((state_q == S_CMD) || (state_q == S_ADDR) ||
                    ((state_q == S_DATA) && (cnt_q != '0)))
                    frame_err_q <= 1'b1;
                state_q <= S_IDLE;
                cnt_q   <= '0;
                sh_q    <= '0;
                tx_q    <= '0;
                miso_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        sh_q    <= asm_d;
                        cnt_q   <= CNT_W'(1);
                        state_q <= S_CMD;
                        miso_q  <= 1'b0;
                    end
                    S_CMD: begin
                        if (last_cmd) begin
                            sh_q  <= '0;
                            cnt_q <= '0;
                            if ((asm_d[7:0] == 8'h03) || (asm_d[7:0] == 8'h02)) begin
                                rd_q        <= (asm_d[7:0] == 8'h03);
                                state_q     <= S_ADDR;
                                frame_err_q <= 1'b0;
                            end else begin
                                state_q     <= S_IGNORE;
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            sh_q  <= asm_d;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_ADDR: begin
                        if (last_addr) begin
                            addr_q  <= asm_d[ADDR_W-1:0];
                            sh_q    <= '0;
                            cnt_q   <= '0;
                            state_q <= S_DATA;
                            if (rd_q) begin
                                tx_q   <= shift_word(rd_word);
                                miso_q <= first_bit(rd_word);
                            end
                        end else begin
                            sh_q  <= asm_d;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (rd_q) begin
                            if (last_word) begin
                                addr_q      <= addr_inc;
                                tx_q        <= shift_word(rd_word);
                                miso_q      <= first_bit(rd_word);
                                word_done_q <= 1'b1;
                                cnt_q       <= '0;
                            end else begin
                                tx_q   <= shift_word(tx_q);
                                miso_q <= first_bit(tx_q);
                                cnt_q  <= cnt_q + CNT_W'(1);
                            end
                        end else begin
                            miso_q <= 1'b0;
                            if (last_word) begin
                                addr_q      <= addr_inc;
                                word_done_q <= 1'b1;
                                cnt_q       <= '0;
                                sh_q        <= '0;
                            end else begin
                                sh_q  <= asm_d;
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    S_IGNORE: miso_q <= 1'b0;
                    default: begin
                        state_q <= S_IDLE;
                        miso_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign MISO     = miso_q;
    assign busy     = (state_q != S_IDLE);
    assign wordDone = word_done_q;
    assign frameErr = frame_err_q;

endmodule

// File: tb/tb_spi_sram_burst.sv
// Directed bench for spi_sram_burst: default 8/8 MSB-first instance and a
// 16-bit data / 4-bit address LSB-first instance sharing one SCK.
module tb_spi_sram_burst;

    logic SCK   = 1'b0;
    logic rst_n = 1'b1;

    logic csn_a = 1'b1, mosi_a = 1'b0;
    logic miso_a, busy_a, wd_o_a, err_a;
    logic csn_b = 1'b1, mosi_b = 1'b0;
    logic miso_b, busy_b, wd_o_b, err_b;

    int n_cmp = 0;
    int n_err = 0;
    int wd_a  = 0;
    int wd_b  = 0;

    spi_sram_burst u_a (
        .SCK(SCK), .rst_n(rst_n), .csN(csn_a), .MOSI(mosi_a),
        .MISO(miso_a), .busy(busy_a), .wordDone(wd_o_a), .frameErr(err_a)
    );

    spi_sram_burst #(.DATA_W(16), .ADDR_W(4), .LSB_FIRST(1)) u_b (
        .SCK(SCK), .rst_n(rst_n), .csN(csn_b), .MOSI(mosi_b),
        .MISO(miso_b), .busy(busy_b), .wordDone(wd_o_b), .frameErr(err_b)
    );

    always #5 SCK = ~SCK;

    always @(negedge SCK) begin
        if (wd_o_a === 1'b1) wd_a++;
        if (wd_o_b === 1'b1) wd_b++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One SPI bit: MISO is taken just before the posedge the master samples on.
    task automatic clk_bit(input bit sel, input logic b, output logic mi);
        @(negedge SCK);
        mi = sel ? miso_b : miso_a;
        if (sel) begin csn_b = 1'b0; mosi_b = b; end
        else     begin csn_a = 1'b0; mosi_a = b; end
        @(posedge SCK);
        #1;
    endtask

    task automatic xfer(input bit sel, input logic [15:0] val, input int w,
                        input bit lsb, output logic [15:0] rx);
        logic m;
        int   pos;
        rx = '0;
        for (int i = 0; i < w; i++) begin
            pos = lsb ? i : (w - 1 - i);
            clk_bit(sel, val[pos], m);
            rx[pos] = m;
        end
    endtask

    task automatic end_frame(input bit sel);
        @(negedge SCK);
        if (sel) begin csn_b = 1'b1; mosi_b = 1'b0; end
        else     begin csn_a = 1'b1; mosi_a = 1'b0; end
        @(posedge SCK);
        #1;
    endtask

    initial begin
        logic [15:0] rx;
        logic        m;
        int          wd0;

        #2 rst_n = 1'b0;
        #1;
        chk("reset_a", {12'h0, miso_a, busy_a, wd_o_a, err_a}, 16'h0);
        chk("reset_b", {12'h0, miso_b, busy_b, wd_o_b, err_b}, 16'h0);
        repeat (2) @(negedge SCK);
        rst_n = 1'b1;

        // single write 02,10,A5
        xfer(0, 16'h02, 8, 0, rx);
        xfer(0, 16'h10, 8, 0, rx);
        chk("busy_mid", {15'h0, busy_a}, 16'h1);
        xfer(0, 16'hA5, 8, 0, rx);
        chk("wd_at_bit24", {15'h0, wd_o_a}, 16'h1);
        end_frame(0);
        chk("busy_fall", {15'h0, busy_a}, 16'h0);
        chk("wd_count_single", 16'(wd_a), 16'd1);

        xfer(0, 16'h02, 8, 0, rx);
        xfer(0, 16'h20, 8, 0, rx);
        xfer(0, 16'h3C, 8, 0, rx);
        end_frame(0);

        // read back 0x10
        xfer(0, 16'h03, 8, 0, rx);
        xfer(0, 16'h10, 8, 0, rx);
        xfer(0, 16'h00, 8, 0, rx);
        chk("read_10", rx, 16'hA5);
        end_frame(0);

        // burst write with wrap
        wd0 = wd_a;
        xfer(0, 16'h02, 8, 0, rx);
        xfer(0, 16'hFE, 8, 0, rx);
        xfer(0, 16'h11, 8, 0, rx);
        xfer(0, 16'h22, 8, 0, rx);
        xfer(0, 16'h33, 8, 0, rx);
        end_frame(0);
        chk("wd_count_burst", 16'(wd_a - wd0), 16'd3);
        chk("err_after_burst", {15'h0, err_a}, 16'h0);

        xfer(0, 16'h03, 8, 0, rx);
        xfer(0, 16'hFE, 8, 0, rx);
        xfer(0, 16'h00, 8, 0, rx);
        chk("burst_rd_FE", rx, 16'h11);
        xfer(0, 16'h00, 8, 0, rx);
        chk("burst_rd_FF", rx, 16'h22);
        xfer(0, 16'h00, 8, 0, rx);
        chk("burst_rd_00", rx, 16'h33);
        end_frame(0);

        xfer(0, 16'h03, 8, 0, rx);
        xfer(0, 16'hFF, 8, 0, rx);
        xfer(0, 16'h00, 8, 0, rx);
        chk("wrap_rd_w0", rx, 16'h22);
        xfer(0, 16'h00, 8, 0, rx);
        chk("wrap_rd_w1", rx, 16'h33);
        end_frame(0);

        // invalid command: rest of frame ignored, MISO held low
        xfer(0, 16'h55, 8, 0, rx);
        chk("err_bad_cmd", {15'h0, err_a}, 16'h1);
        xfer(0, 16'h02, 8, 0, rx);
        xfer(0, 16'h10, 8, 0, rx);
        xfer(0, 16'hFF, 8, 0, rx);
        chk("ignore_miso", rx, 16'h00);
        end_frame(0);
        chk("err_sticky", {15'h0, err_a}, 16'h1);

        // valid command clears, partial word sets
        xfer(0, 16'h02, 8, 0, rx);
        chk("err_clear", {15'h0, err_a}, 16'h0);
        xfer(0, 16'h20, 8, 0, rx);
        for (int i = 0; i < 3; i++) clk_bit(0, 1'b1, m);
        end_frame(0);
        chk("err_partial", {15'h0, err_a}, 16'h1);

        // reset mid data word
        xfer(0, 16'h02, 8, 0, rx);
        xfer(0, 16'h10, 8, 0, rx);
        for (int i = 0; i < 4; i++) clk_bit(0, 1'b1, m);
        chk("busy_pre_abort", {15'h0, busy_a}, 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outs", {12'h0, miso_a, busy_a, wd_o_a, err_a}, 16'h0);
        csn_a = 1'b1;
        @(negedge SCK);
        rst_n = 1'b1;

        xfer(0, 16'h03, 8, 0, rx);
        xfer(0, 16'h20, 8, 0, rx);
        xfer(0, 16'h00, 8, 0, rx);
        chk("partial_untouched", rx, 16'h3C);
        end_frame(0);
        xfer(0, 16'h03, 8, 0, rx);
        xfer(0, 16'h10, 8, 0, rx);
        xfer(0, 16'h00, 8, 0, rx);
        chk("abort_untouched", rx, 16'hA5);
        end_frame(0);

        // deselect inside the command byte
        for (int i = 0; i < 4; i++) clk_bit(0, 1'b0, m);
        end_frame(0);
        chk("err_cs_in_cmd", {15'h0, err_a}, 16'h1);

        // 16-bit data, 4-bit address, LSB-first
        xfer(1, 16'h02, 8, 1, rx);
        xfer(1, 16'h000F, 4, 1, rx);
        xfer(1, 16'hBEEF, 16, 1, rx);
        xfer(1, 16'hBEEF, 16, 1, rx);
        xfer(1, 16'h1234, 16, 1, rx);
        end_frame(1);
        chk("b_wd_count", 16'(wd_b), 16'd3);

        xfer(1, 16'h03, 8, 1, rx);
        xfer(1, 16'h000F, 4, 1, rx);
        xfer(1, 16'h0000, 16, 1, rx);
        chk("b_rd_F", rx, 16'hBEEF);
        xfer(1, 16'h0000, 16, 1, rx);
        chk("b_rd_0_wrap", rx, 16'hBEEF);
        xfer(1, 16'h0000, 16, 1, rx);
        chk("b_rd_1", rx, 16'h1234);
        end_frame(1);
        chk("b_err", {15'h0, err_b}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
